// File: rtl/checkbits_pkg.sv
// checkbits_pkg
// Shared definitions for the checkpoint sequence monitor: the FSM state
// type, default sizing constants and the firmware marker values that open
// and close a test run.
// Optional feature macro used in this slice: CHECKBITS_MASK_EN.
package checkbits_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } cb_state_t;

    localparam int CB_WIDTH      = 16;
    localparam int CB_DEPTH      = 8;
    localparam int CB_TMO_W      = 20;
    localparam int CB_STABLE_CYC = 2;

    localparam logic [15:0] CB_TEST_START = 16'hAB40;
    localparam logic [15:0] CB_TEST_PASS  = 16'hAB51;

endpackage

// File: rtl/checkbits_seq_monitor_if.sv
// checkbits_seq_monitor_if
// Configuration/control and status bundle of the checkpoint monitor.
//   master : drives cfg_we/cfg_addr/cfg_data/cfg_len/cfg_tmo/start/abort
//            (and cfg_mask), reads busy/pass/fail/step_idx/hit_pulse/hit_value
//   slave  : the monitor itself, opposite directions
// CHECKBITS_MASK_EN adds cfg_mask, written alongside cfg_data.
interface checkbits_seq_monitor_if #(
    parameter int WIDTH = checkbits_pkg::CB_WIDTH,
    parameter int DEPTH = checkbits_pkg::CB_DEPTH,
    parameter int TMO_W = checkbits_pkg::CB_TMO_W
);
    logic                     cfg_we;
    logic [$clog2(DEPTH)-1:0] cfg_addr;
    logic [WIDTH-1:0]         cfg_data;
`ifdef CHECKBITS_MASK_EN
    logic [WIDTH-1:0]         cfg_mask;
`endif
    logic [$clog2(DEPTH):0]   cfg_len;
    logic [TMO_W-1:0]         cfg_tmo;
    logic                     start;
    logic                     abort;
    logic                     busy;
    logic                     pass;
    logic                     fail;
    logic [$clog2(DEPTH):0]   step_idx;
    logic                     hit_pulse;
    logic [WIDTH-1:0]         hit_value;

    modport master (
`ifdef CHECKBITS_MASK_EN
        output cfg_mask,
`endif
        output cfg_we, cfg_addr, cfg_data, cfg_len, cfg_tmo, start, abort,
        input  busy, pass, fail, step_idx, hit_pulse, hit_value
    );

    modport slave (
`ifdef CHECKBITS_MASK_EN
        input  cfg_mask,
`endif
        input  cfg_we, cfg_addr, cfg_data, cfg_len, cfg_tmo, start, abort,
        output busy, pass, fail, step_idx, hit_pulse, hit_value
    );

endinterface

// File: rtl/checkbits_sync.sv
// checkbits_sync
// Two-flop synchronizer for the firmware-driven checkpoint bus.
//   clk, rst : clock and asynchronous active-high reset (flops clear to 0)
//   d        : asynchronous input bus
//   q        : synchronized bus, two cycles behind d
module checkbits_sync #(
    parameter int WIDTH = checkbits_pkg::CB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// checkbits_seq_monitor
// Watches the checkpoint bus and matches it against a programmed, ordered
// list of expected values, each with its own cycle timeout.
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   checkbits_i        : firmware checkpoint bus (asynchronous)
//   bus (slave)        : entry writes, cfg_len/cfg_tmo, start/abort,
//                        busy/pass/fail/step_idx/hit_pulse/hit_value
// Build option CHECKBITS_MASK_EN: per-entry compare mask table.
//
// state | meaning
// IDLE  | not monitoring, table writable
// RUN   | qualifying entry[step_idx] on the synced bus, timeout running
// PASS  | every active entry matched (pass sticky), table writable
// FAIL  | a step timed out (fail sticky, step_idx frozen), table writable
module checkbits_seq_monitor
    import checkbits_pkg::*;
#(
    parameter int WIDTH      = CB_WIDTH,
    parameter int DEPTH      = CB_DEPTH,
    parameter int TMO_W      = CB_TMO_W,
    parameter int STABLE_CYC = CB_STABLE_CYC
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [WIDTH-1:0]       checkbits_i,
    checkbits_seq_monitor_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STABLE_CYC + 1);

    logic [WIDTH-1:0] cb_sync;
    logic [WIDTH-1:0] entry_q [DEPTH];
`ifdef CHECKBITS_MASK_EN
    logic [WIDTH-1:0] mask_q [DEPTH];
`endif

    cb_state_t        state;
    logic [LW-1:0]    len_q;
    logic [TMO_W-1:0] tmo_q;
    logic [TMO_W-1:0] tmo_cnt;
    logic [SW-1:0]    stable_cnt;
    logic [LW-1:0]    step_q;
    logic             busy_q;
    logic             pass_q;
    logic             fail_q;
    logic             hit_pulse_q;
    logic [WIDTH-1:0] hit_value_q;

    logic             match;
    logic             stable_done;
    logic             tmo_done;
    logic             last_step;
    logic [LW-1:0]    len_clamped;

    checkbits_sync #(.WIDTH(WIDTH)) u_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (checkbits_i),
        .q   (cb_sync)
    );

    // Table has no reset; it is only writable while not monitoring so a
    // running sequence cannot be changed underneath the FSM.
    always_ff @(posedge wb_clk_i) begin
        if (bus.cfg_we && state != RUN) begin
            entry_q[bus.cfg_addr] <= bus.cfg_data;
`ifdef CHECKBITS_MASK_EN
            mask_q[bus.cfg_addr]  <= bus.cfg_mask;
`endif
        end
    end

    always_comb begin
`ifdef CHECKBITS_MASK_EN
        match = ((cb_sync ^ entry_q[step_q[AW-1:0]]) & mask_q[step_q[AW-1:0]]) == '0;
`else
        match = (cb_sync == entry_q[step_q[AW-1:0]]);
`endif
        // The current match is the last of STABLE_CYC consecutive ones.
        stable_done = match && (stable_cnt == SW'(STABLE_CYC - 1));
        tmo_done    = (tmo_q != '0) && (tmo_cnt == tmo_q - TMO_W'(1));
        last_step   = (step_q == len_q - LW'(1));
        // A length beyond the table would index past its end.
        len_clamped = (bus.cfg_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.cfg_len;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            len_q       <= '0;
            tmo_q       <= '0;
            tmo_cnt     <= '0;
            stable_cnt  <= '0;
            step_q      <= '0;
            busy_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            hit_pulse_q <= 1'b0;
            hit_value_q <= '0;
        end else begin
            hit_pulse_q <= 1'b0;
            if (bus.abort) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                pass_q <= 1'b0;
                fail_q <= 1'b0;
            end else begin
                case (state)
                    IDLE, PASS, FAIL: begin
                        if (bus.start) begin
                            len_q      <= len_clamped;
                            tmo_q      <= bus.cfg_tmo;
                            tmo_cnt    <= '0;
                            stable_cnt <= '0;
                            step_q     <= '0;
                            fail_q     <= 1'b0;
                            if (len_clamped == '0) begin
                                state  <= PASS;
                                pass_q <= 1'b1;
                                busy_q <= 1'b0;
                            end else begin
                                state  <= RUN;
                                pass_q <= 1'b0;
                                busy_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (stable_done) begin
                            // A hit wins over a timeout landing on the same cycle.
                            hit_pulse_q <= 1'b1;
                            hit_value_q <= cb_sync;
                            step_q      <= step_q + LW'(1);
                            stable_cnt  <= '0;
                            tmo_cnt     <= '0;
                            if (last_step) begin
                                state  <= PASS;
                                pass_q <= 1'b1;
                                busy_q <= 1'b0;
                            end
                        end else if (tmo_done) begin
                            state  <= FAIL;
                            fail_q <= 1'b1;
                            busy_q <= 1'b0;
                        end else begin
                            // stable_cnt never passes STABLE_CYC-1: reaching it is a hit.
                            stable_cnt <= match ? stable_cnt + SW'(1) : '0;
                            if (tmo_cnt != '1) begin
                                tmo_cnt <= tmo_cnt + TMO_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.pass      = pass_q;
    assign bus.fail      = fail_q;
    assign bus.step_idx  = step_q;
    assign bus.hit_pulse = hit_pulse_q;
    assign bus.hit_value = hit_value_q;

endmodule
